// File: rtl/m_digest_serializer.sv
// Streams a captured 256-bit digest to a byte-wide UART transmitter, either as
// raw bytes or as lowercase ASCII hex, with an optional CR/LF trailer.
module m_digest_serializer #(
  parameter int P_ASCII   = 0,
  parameter int P_NEWLINE = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_hash_done,
  input  logic [255:0] i_digest,
  input  logic         i_tx_busy,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_start,
  output logic         o_busy,
  output logic         o_done
);

  localparam int         N_BODY   = (P_ASCII != 0) ? 64 : 32;
  localparam int         N_CHARS  = N_BODY + ((P_NEWLINE != 0) ? 2 : 0);
  localparam logic [6:0] BODY_IDX = 7'(N_BODY);
  localparam logic [6:0] LAST_IDX = 7'(N_CHARS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ACK,
    DRAIN,
    DONE
  } state_t;

  state_t       state_reg, state_next;
  logic [255:0] hold_reg, hold_next;
  logic [6:0]   cnt_reg, cnt_next;
  logic [7:0]   tx_data_reg, tx_data_next;
  logic         tx_start_reg, tx_start_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;
  logic         hd_cur_reg, hd_prev_reg;
  logic         hd_rise;

  logic [7:0]   digest_byte [32];
  logic [4:0]   byte_idx;
  logic [7:0]   sel_byte;
  logic [3:0]   sel_nibble;
  logic [7:0]   cur_char;

  // Byte 0 is the most significant byte of the held digest.
  for (genvar gi = 0; gi < 32; gi++) begin : g_bytes
    assign digest_byte[gi] = hold_reg[255-8*gi -: 8];
  end

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Two-stage history: the rise is seen one clock after the level is sampled.
  assign hd_rise = hd_cur_reg & ~hd_prev_reg;

  always_comb begin
    byte_idx   = (P_ASCII != 0) ? cnt_reg[5:1] : cnt_reg[4:0];
    sel_byte   = digest_byte[byte_idx];
    sel_nibble = cnt_reg[0] ? sel_byte[3:0] : sel_byte[7:4];
    cur_char   = sel_byte;
    if (cnt_reg == BODY_IDX) begin
      cur_char = 8'h0D;
    end else if (cnt_reg == BODY_IDX + 7'd1) begin
      cur_char = 8'h0A;
    end else if (P_ASCII != 0) begin
      cur_char = hex_char(sel_nibble);
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_next     = hold_reg;
    cnt_next      = cnt_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hd_rise) begin
          hold_next  = i_digest;
          cnt_next   = 7'd0;
          state_next = START;
        end
      end
      START: begin
        if (!i_tx_busy) begin
          tx_data_next  = cur_char;
          tx_start_next = 1'b1;
          state_next    = ACK;
        end
      end
      ACK: begin
        if (i_tx_busy) state_next = DRAIN;
      end
      DRAIN: begin
        if (!i_tx_busy) begin
          cnt_next   = cnt_reg + 7'd1;
          state_next = (cnt_reg == LAST_IDX) ? DONE : START;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg    <= IDLE;
      hold_reg     <= '0;
      cnt_reg      <= 7'd0;
      tx_data_reg  <= 8'h00;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      hd_cur_reg   <= 1'b0;
      hd_prev_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      cnt_reg      <= cnt_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      hd_cur_reg   <= i_hash_done;
      hd_prev_reg  <= hd_cur_reg;
    end
  end

  assign o_tx_data  = tx_data_reg;
  assign o_tx_start = tx_start_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;

endmodule

// File: doc/m_digest_serializer.md
M_DIGEST_SERIALIZER -- requirements
Module: m_digest_serializer

Interface
REQ-001 The block SHALL have parameter P_ASCII, default 0; 1 = send each digest byte as two lowercase ASCII hex characters, 0 = send raw bytes.
REQ-002 The block SHALL have parameter P_NEWLINE, default 0; 1 = append 0x0D then 0x0A after the digest.
REQ-003 The block SHALL have port i_clk, input, 1, system clock; all logic on the rising edge.
REQ-004 The block SHALL have port i_rst, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port i_hash_done, input, 1, digest-valid level from the hash core; a rising edge requests transmission.
REQ-006 The block SHALL have port i_digest, input, 256, final hash; H0 in [255:224] and H7 in [31:0].
REQ-007 The block SHALL have port i_tx_busy, input, 1, UART transmitter busy.
REQ-008 The block SHALL have port o_tx_data, output, 8, byte presented to the UART transmitter.
REQ-009 The block SHALL have port o_tx_start, output, 1, single-cycle request to send o_tx_data.
REQ-010 The block SHALL have port o_busy, output, 1, high from capture until the o_done pulse.
REQ-011 The block SHALL have port o_done, output, 1, single-cycle pulse after the last character is drained.

Function
REQ-012 The block SHALL implement FSM states IDLE, START, ACK, DRAIN and DONE; all outputs registered.
REQ-013 In IDLE, on a sampled rising edge of i_hash_done (current=1, previous=0), the block SHALL copy i_digest into a 256-bit holding register, clear the character counter and go to START.
REQ-014 In START with i_tx_busy=0, the block SHALL drive o_tx_data with the current character, pulse o_tx_start for exactly one cycle and go to ACK; with i_tx_busy=1 it SHALL stay in START with o_tx_start=0.
REQ-015 In ACK, the block SHALL wait for i_tx_busy=1, then go to DRAIN.
REQ-016 In DRAIN, the block SHALL wait for i_tx_busy=0, then increment the counter; it SHALL go to DONE if that was the last character, otherwise to START.
REQ-017 In DONE, the block SHALL assert o_done for one cycle and return to IDLE.
REQ-018 o_tx_data SHALL remain stable from the o_tx_start cycle until the DRAIN exit.
REQ-019 Byte order SHALL be MSB first: i_digest[255:248] first and i_digest[7:0] last.
REQ-020 In ASCII mode, each byte SHALL be sent high nibble first; nibble 0-9 maps to 0x30-0x39 and a-f maps to 0x61-0x66.
REQ-021 Character count SHALL be 32 raw or 64 ASCII, plus 2 with P_NEWLINE; the counter SHALL be 7 bits wide and SHALL never wrap within a message.
REQ-022 The first o_tx_start SHALL occur 2 clocks after the edge that samples the i_hash_done rise, provided i_tx_busy=0.
REQ-023 Changes on i_digest after capture SHALL NOT affect the output.
REQ-024 i_hash_done edges outside IDLE SHALL be ignored and not queued; the edge detector SHALL keep tracking i_hash_done in every state.
REQ-025 i_hash_done held high after DONE SHALL NOT retrigger.
REQ-026 o_busy SHALL be 1 in START, ACK, DRAIN and DONE, and 0 in IDLE.

Reset
REQ-027 With i_rst=0 at a clock edge, the block SHALL enter IDLE with o_tx_data=0x00, o_tx_start=0, o_busy=0, o_done=0, counter=0, holding register=0 and edge-detect history=0.
REQ-028 Reset mid-transmission SHALL abort immediately with no o_done pulse; the next request SHALL restart at character 0.
REQ-029 If i_hash_done is high when reset is released, this SHALL count as a rising edge.

Verification
REQ-030 Raw mode, digest ba7816bf...f20015ad ("abc"), UART model raising busy 1 cycle after start for 10 cycles -> 32 o_tx_start pulses with bytes 0xBA, 0x78, 0x16, 0xBF ... 0x15, 0xAD, then exactly one o_done pulse.
REQ-031 P_ASCII=1, P_NEWLINE=1, same digest -> 66 characters: 0x62, 0x61, 0x37, 0x38 ... 0x61, 0x64, 0x0D, 0x0A.
REQ-032 i_tx_busy held 1 for 50 cycles at request time -> no o_tx_start and o_busy=1 until release; first start 1 cycle after release.
REQ-033 i_hash_done held high for 500 cycles past o_done -> no second message; after a 0 -> 1 toggle, the full message is re-sent.
REQ-034 i_rst=0 during character 10 -> all outputs at reset values next cycle and no o_done; a new request sends from 0xBA.
REQ-035 i_digest changed to all-ones and an i_hash_done re-pulse mid-message -> the original 32 bytes are sent unchanged and no extra message follows.
